i2c_debug_trace: RTL
====================

Name: i2c_debug_trace

Overview:
- Parametrised successor to the I2C debug/test block.
- Captures timestamped snapshots of a generic probe bus into a circular trace buffer.
- Evaluates a masked breakpoint on the same bus and can halt the I2C core on a hit.
- Sits beside the I2C core on the system clock. The debug host reads and writes it through a strobe-based register port with registered, single-cycle read return.

Parameters:
- PROBE_W, 16: probe bus width. Rule: PROBE_W + TS_W <= 32.
- TS_W, 16: timestamp counter width.
- DEPTH, 16: trace entries. Power of two, 2..128.
- CNT_W, $clog2(DEPTH+1): occupancy counter width.

Ports:
- i_sys_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_probe  in  PROBE_W  probed signals, e.g. {busy, state, scl/sda in/out, shift_reg}.
- i_dbg_addr  in  8  register byte address.
- i_dbg_wdata  in  32  write data.
- i_dbg_write  in  1  write strobe, one cycle per access.
- i_dbg_read  in  1  read strobe, one cycle per access.
- o_dbg_rdata  out  32  read data, valid when o_dbg_rvalid=1.
- o_dbg_rvalid  out  1  pulses one cycle after i_dbg_read.
- o_halt  out  1  request to freeze the I2C core.
- o_break_irq  out  1  level interrupt, equals the sticky break flag.

Behaviour:
- Reset state: all registers 0, buffer empty, timestamp 0, prev_probe 0. Outputs o_dbg_rdata=0, o_dbg_rvalid=0, o_halt=0, o_break_irq=0. Reset mid-capture discards buffer contents.
- Registers:
  - 0x00 CTRL (RW):
    - [0] EN: capture/timestamp enable.
    - [1] MODE: 0 = capture on change, 1 = capture every cycle.
    - [2] HALT_EN.
    - [3] STOP_FULL: 1 = drop when full, 0 = overwrite oldest.
    - [4] CLR: write-1 self-clearing; empties buffer, zeroes timestamp and overflow. Reads as 0.
  - 0x04 STATUS:
    - [0] BRK: sticky, W1C.
    - [1] FULL, RO.
    - [2] EMPTY, RO.
    - [3] OVF: sticky, W1C.
    - [15:8] COUNT, RO, zero-extended.
  - 0x08 BRK_VAL [PROBE_W-1:0] (RW).
  - 0x0C BRK_MASK [PROBE_W-1:0] (RW).
  - 0x10 TRACE (RO, pop): {zero-pad, timestamp, probe} of the oldest entry. Read when empty returns 0 with no pointer change.
  - 0x14 TSTAMP (RO): live counter.
  - Other addresses read 0; writes to them are ignored.
- Read timing: the read strobe at cycle N gives o_dbg_rdata/o_dbg_rvalid at N+1. o_dbg_rdata holds its value until the next read. A simultaneous read and write are both performed; the read returns the pre-write value.
- Timestamp: increments every cycle while EN=1 and not halted. Wraps modulo 2^TS_W.
- Capture condition: EN & ~halted & (MODE | (i_probe != prev_probe)).
  - prev_probe updates every cycle while EN=1.
  - Entry stored = {timestamp before increment, i_probe}.
- Full handling:
  - STOP_FULL=1: capture is dropped and OVF is set.
  - STOP_FULL=0: the oldest entry is overwritten, read pointer advances, count stays DEPTH, OVF is set.
- Simultaneous capture and TRACE pop: the pop takes the oldest entry and the push is written. Count is unchanged. No OVF, even when full.
- Breakpoint: hit = EN & (BRK_MASK != 0) & (((i_probe ^ BRK_VAL) & BRK_MASK) == 0).
  - A hit sets BRK on the next edge.
  - The hitting sample is still captured if its capture condition holds.
  - halted = BRK & HALT_EN, registered; o_halt rises one cycle after the hit edge.
- Halted: capture and timestamp freeze; TRACE pops remain allowed.
- Clearing BRK: W1C of BRK clears BRK; o_halt falls the cycle after. A hit in the same cycle as the W1C wins, so BRK stays 1.
- CLR concurrent with a capture: CLR wins and the buffer ends empty.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset: assert i_rst mid-run → all outputs 0 asynchronously; STATUS read returns 0x00000004.
- Change capture: CTRL=0x1, drive probe 0x0000 → 0x00A5 at ts 5 → 0x00A5 held 3 cycles → 0x1234 → COUNT=2. TRACE reads return 0x000500A5, then {ts,0x1234}, then 0.
- Wrap overflow: DEPTH=16, CTRL=0x3 for 20 cycles → FULL=1, OVF=1, COUNT=16; the first TRACE read gives the timestamp field = 4. With CTRL=0xB (STOP_FULL) the first read gives 0.
- Breakpoint halt: BRK_VAL=0x0040, BRK_MASK=0x00F0, CTRL=0x5; probe hits 0x0045 → BRK=1 next edge, o_halt=1 one cycle later, TSTAMP frozen. W1C STATUS=0x1 → o_halt=0, capture resumes.
- Pop while full: wrap mode with buffer full, a capture coincides with a TRACE read → COUNT stays 16, OVF unchanged, oldest entry returned.
- Edge cases:
  - BRK_MASK=0 → no hit ever.
  - TS wrap 0xFFFF → 0x0000 recorded correctly.
  - CLR during capture → EMPTY=1, TSTAMP=0.

Source files
------------

// File: rtl/i2c_debug_trace.sv
// Debug companion for the I2C core: timestamped probe trace buffer, masked
// breakpoint with optional core halt, and a strobe-based register port.
`timescale 1ns/1ps
module i2c_debug_trace #(
  parameter int PROBE_W = 16,
  parameter int TS_W    = 16,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               i_sys_clk,
  input  logic               i_rst,
  input  logic [PROBE_W-1:0] i_probe,
  input  logic [7:0]         i_dbg_addr,
  input  logic [31:0]        i_dbg_wdata,
  input  logic               i_dbg_write,
  input  logic               i_dbg_read,
  output logic [31:0]        o_dbg_rdata,
  output logic               o_dbg_rvalid,
  output logic               o_halt,
  output logic               o_break_irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = TS_W + PROBE_W;

  logic               en_r, mode_r, halt_en_r, stop_full_r;
  logic               brk_r, ovf_r, halted_r;
  logic [PROBE_W-1:0] brk_val_r, brk_mask_r, prev_probe_r;
  logic [TS_W-1:0]    ts_r;
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [ENT_W-1:0]   mem_r [DEPTH];
  logic [31:0]        rdata_r;
  logic               rvalid_r;

  logic        wr_ctrl_s, wr_status_s, wr_val_s, wr_mask_s, sel_trace_s;
  logic [31:0] rd_mux_s;
  logic        full_s, empty_s, pop_s, cap_s, hit_s, clr_s;
  logic        push_s, overwrite_s, ovf_set_s;
  logic        unused_s;

  assign full_s   = (count_r == CNT_W'(DEPTH));
  assign empty_s  = (count_r == {CNT_W{1'b0}});
  assign clr_s    = wr_ctrl_s & i_dbg_wdata[4];
  assign pop_s    = i_dbg_read & sel_trace_s & ~empty_s;
  assign cap_s    = en_r & ~halted_r & (mode_r | (i_probe != prev_probe_r));
  assign hit_s    = en_r & (brk_mask_r != {PROBE_W{1'b0}}) &
                    (((i_probe ^ brk_val_r) & brk_mask_r) == {PROBE_W{1'b0}});
  assign unused_s = ^i_dbg_wdata;

  // Address decode: write selects and the read-data mux
  always_comb begin
    wr_ctrl_s   = 1'b0;
    wr_status_s = 1'b0;
    wr_val_s    = 1'b0;
    wr_mask_s   = 1'b0;
    sel_trace_s = 1'b0;
    rd_mux_s    = 32'h0000_0000;
    case (i_dbg_addr)
      8'h00: begin
        wr_ctrl_s = i_dbg_write;
        rd_mux_s  = {28'h000_0000, stop_full_r, halt_en_r, mode_r, en_r};
      end
      8'h04: begin
        wr_status_s = i_dbg_write;
        rd_mux_s    = {16'h0000, 8'(count_r), 4'h0, ovf_r, empty_s, full_s, brk_r};
      end
      8'h08: begin
        wr_val_s = i_dbg_write;
        rd_mux_s = 32'(brk_val_r);
      end
      8'h0C: begin
        wr_mask_s = i_dbg_write;
        rd_mux_s  = 32'(brk_mask_r);
      end
      8'h10: begin
        sel_trace_s = 1'b1;
        if (empty_s) rd_mux_s = 32'h0000_0000;
        else         rd_mux_s = 32'(mem_r[rd_ptr_r]);
      end
      8'h14:   rd_mux_s = 32'(ts_r);
      default: rd_mux_s = 32'h0000_0000;
    endcase
  end

  // A coincident pop frees a slot, so a capture on a full buffer only
  // counts as an overflow when no TRACE read lands in the same cycle.
  always_comb begin
    push_s      = 1'b0;
    overwrite_s = 1'b0;
    ovf_set_s   = 1'b0;
    if (cap_s & ~clr_s) begin
      if (pop_s | ~full_s) begin
        push_s = 1'b1;
      end else if (stop_full_r) begin
        ovf_set_s = 1'b1;
      end else begin
        push_s      = 1'b1;
        overwrite_s = 1'b1;
        ovf_set_s   = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Control/breakpoint registers, sticky flags and the halt request
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      en_r <= 1'b0; mode_r <= 1'b0; halt_en_r <= 1'b0; stop_full_r <= 1'b0;
      brk_r <= 1'b0; ovf_r <= 1'b0; halted_r <= 1'b0;
      brk_val_r <= {PROBE_W{1'b0}}; brk_mask_r <= {PROBE_W{1'b0}};
    end else begin
      if (wr_ctrl_s) begin
        en_r        <= i_dbg_wdata[0];
        mode_r      <= i_dbg_wdata[1];
        halt_en_r   <= i_dbg_wdata[2];
        stop_full_r <= i_dbg_wdata[3];
      end
      if (wr_val_s)  brk_val_r  <= i_dbg_wdata[PROBE_W-1:0];
      if (wr_mask_s) brk_mask_r <= i_dbg_wdata[PROBE_W-1:0];
      if (hit_s) brk_r <= 1'b1;
      else if (wr_status_s & i_dbg_wdata[0]) brk_r <= 1'b0;
      if (clr_s) ovf_r <= 1'b0;
      else if (ovf_set_s) ovf_r <= 1'b1;
      else if (wr_status_s & i_dbg_wdata[3]) ovf_r <= 1'b0;
      halted_r <= brk_r & halt_en_r;
    end
  end

  // Timestamp, change detector and buffer pointers
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      ts_r <= {TS_W{1'b0}}; prev_probe_r <= {PROBE_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}}; rd_ptr_r <= {PTR_W{1'b0}}; count_r <= {CNT_W{1'b0}};
    end else begin
      if (en_r) prev_probe_r <= i_probe;
      if (clr_s) begin
        ts_r <= {TS_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}}; rd_ptr_r <= {PTR_W{1'b0}}; count_r <= {CNT_W{1'b0}};
      end else begin
        if (en_r & ~halted_r) ts_r <= ts_r + TS_W'(1);
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (pop_s | overwrite_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        if (push_s & ~pop_s & ~overwrite_s) count_r <= count_r + CNT_W'(1);
        else if (pop_s & ~push_s) count_r <= count_r - CNT_W'(1);
      end
    end
  end

  // Trace storage; stale contents are unreachable once pointers reset
  always_ff @(posedge i_sys_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {ts_r, i_probe};
  end

  // Registered read return, held until the next read strobe
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_r  <= 32'h0000_0000;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= i_dbg_read;
      if (i_dbg_read) rdata_r <= rd_mux_s;
    end
  end

  assign o_dbg_rdata  = rdata_r;
  assign o_dbg_rvalid = rvalid_r;
  assign o_halt       = halted_r;
  assign o_break_irq  = brk_r;

endmodule
